demux_1x32_ctrl: RTL and testbench
==================================

# demux_1x32_ctrl

Sequencing controller for the 1:32 demultiplexer datapath. It accepts single routing requests over a valid/ready handshake, or a sweep command that walks all 32 channels in order, and drives the demux `i`/`sel` inputs with a programmable hold time per channel. The 32-bit one-hot `y` output is decoded inside the block, so downstream logic sees the routed strobe directly. It sits between the request sources and the 32 destination lines.

## Interface

- `HOLD_CYCLES`, default 2: number of cycles each routed value is held on `sel`/`i`; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  routing request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_dest`  in  5  destination channel 0..31.
- `req_data`  in  1  bit to route to `req_dest`.
- `sweep_start`  in  1  single-cycle command: route `i=1` to channels 0..31 in turn.
- `sel`  out  5  registered demux select.
- `i`  out  1  registered demux data input.
- `y`  out  32  demux output: `y = i ? (32'b1 << sel) : 0`, combinational from the registered `sel`/`i`.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse when a route or sweep completes.

## Operation

- States:
  - IDLE: `i=0`; `sel` holds its last value.
  - ROUTE: `sel` and `i` come from the request latched at acceptance.
  - SWEEP: `i=1`; `sel` steps from 0 to 31.
- `req_ready = (state==IDLE) && !sweep_start && !rst`. A request is accepted on a clock edge where `req_valid && req_ready`.
- IDLE with `sweep_start` high: go to SWEEP. `sweep_start` has priority over a simultaneous `req_valid`; the request is not accepted and must remain asserted.
- IDLE with a request accepted: latch `req_dest` into `sel` and `req_data` into `i`, load the hold counter, and go to ROUTE.
- ROUTE: hold `sel`/`i` for exactly `HOLD_CYCLES` cycles, then return to IDLE with `i=0` and `done=1`.
- `req_data=0` is still a full route: `i=0` and `y=0` for the hold period, and `done` pulses at the end.
- SWEEP: each channel holds for `HOLD_CYCLES` cycles, then `sel` increments by 1. After channel 31's hold, return to IDLE with `done=1`. `sel` never wraps to 0 within a sweep; in IDLE it stays at 31.
- The hold counter is 4 bits. It loads `HOLD_CYCLES-1` and counts down to 0.
- `sweep_start` or `req_valid` while busy: ignored. `sweep_start` is not queued.
- Reset values: state=IDLE, `sel=0`, `i=0`, `y=0`, `busy=0`, `done=0`, `req_ready=0` during the reset cycle.
- Reset mid-operation aborts the route or sweep at that edge. No `done` pulse is produced, and outputs take reset values on the next cycle.

## Timing

- Acceptance edge E: from cycle E+1, `sel`/`i`/`y` show the request and `busy=1`, for `HOLD_CYCLES` cycles.
- Cycle E+1+`HOLD_CYCLES`: IDLE, `i=0`, `y=0`, `busy=0`, `done=1`, `req_ready=1`.
- A new request accepted in the `done` cycle appears on the next cycle. Back-to-back throughput is one request per `HOLD_CYCLES`+1 cycles.
- Sweep starting at edge E: channel n is valid in cycles E+1+n·`HOLD_CYCLES` through E+(n+1)·`HOLD_CYCLES`.
- Sweep completion: `done` pulses in cycle E+1+32·`HOLD_CYCLES`.
- `done` is never high for two consecutive cycles.

## Test plan

All scenarios use `HOLD_CYCLES=2` unless stated.

1. Reset, then a single route of `req_dest=5`, `req_data=1`:
   - `y=32'h0000_0020` for exactly 2 cycles.
   - Then `y=0` with `done=1` for 1 cycle.
   - `req_ready` is low while busy.
2. Back-to-back requests (dest 0, data 1), (dest 31, data 1), (dest 7, data 0), with `req_valid` held high:
   - `y=1` for 2 cycles, then 0 for 1 cycle.
   - Then `y=32'h8000_0000` for 2 cycles, then 0 for 1 cycle.
   - Then `y=0` for 3 cycles with `sel=7`.
   - Three `done` pulses in total.
3. `sweep_start` pulsed together with `req_valid` (dest 3):
   - The request is not accepted.
   - `y` walks 1, 2, 4, …, 32'h8000_0000, each for 2 cycles.
   - `done` pulses 65 cycles after the start edge.
   - The held request is then accepted.
4. `sweep_start` pulsed again mid-sweep and mid-route: ignored; the sequence and `done` timing are unchanged.
5. `rst` asserted during sweep channel 10:
   - Next cycle: `sel=0`, `i=0`, `y=0`, `busy=0`.
   - No `done` pulse.
6. Parameter corners:
   - `HOLD_CYCLES=1`: dest 12 gives `y=32'h0000_1000` for 1 cycle, and the full sweep takes 33 cycles to `done`.
   - `HOLD_CYCLES=15`: each channel is held for 15 cycles.

Source files
------------

// File: rtl/demux_1x32_ctrl_if.sv
// Request/command and demux-side signal bundle for the 1:32 demux sequencing controller.
interface demux_1x32_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_dest;
  logic        req_data;
  logic        sweep_start;
  logic [4:0]  sel;
  logic        i;
  logic [31:0] y;
  logic        busy;
  logic        done;

  // Request source / observer side
  modport master (
    output req_valid, req_dest, req_data, sweep_start,
    input  req_ready, sel, i, y, busy, done
  );

  // Controller side
  modport slave (
    input  req_valid, req_dest, req_data, sweep_start,
    output req_ready, sel, i, y, busy, done
  );
endinterface

// File: rtl/demux_1x32_ctrl.sv
// Sequencing controller for the 1:32 demux: single routed requests or a full
// 0..31 sweep, each value held on sel/i for HOLD_CYCLES cycles, with the
// one-hot demux output decoded from the registered sel/i.
module demux_1x32_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  demux_1x32_ctrl_if.slave bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [4:0] LAST_CH   = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  logic        i_q, i_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  // Sweep commands take priority, so a request is never accepted alongside one.
  assign bus.req_ready = (state_q == IDLE) && !bus.sweep_start && !rst;

  // Next-state, select/data and completion-pulse decision.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        i_d = 1'b0;
        if (bus.sweep_start) begin
          state_d = SWEEP;
          sel_d   = '0;
          i_d     = 1'b1;
          cnt_d   = HOLD_LOAD;
        end else if (bus.req_valid) begin
          state_d = ROUTE;
          sel_d   = bus.req_dest;
          i_d     = bus.req_data;
          cnt_d   = HOLD_LOAD;
        end
      end
      ROUTE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          i_d     = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SWEEP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (sel_q == LAST_CH) begin
          // sel stays on the last channel after the sweep instead of wrapping.
          state_d = IDLE;
          i_d     = 1'b0;
          done_d  = 1'b1;
        end else begin
          sel_d = sel_q + 5'd1;
          cnt_d = HOLD_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        i_d     = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any route or sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      i_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.i    = i_q;
  assign bus.y    = i_q ? (32'd1 << sel_q) : '0;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_demux_1x32_ctrl.sv
// Bench for demux_1x32_ctrl: three instances (hold 2, 1, 15) share stimulus and
// are checked every cycle against a schedule-based model, plus literal pins.
module tb_demux_1x32_ctrl;

  localparam int NI = 3;
  localparam int HV [NI] = '{2, 1, 15};

  typedef struct packed {
    logic [4:0] sel;
    logic       i;
    logic       busy;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_dest = '0;
  logic        req_data = 1'b0;
  logic        sweep_start = 1'b0;

  logic [4:0]  d_sel  [NI];
  logic        d_i    [NI];
  logic [31:0] d_y    [NI];
  logic        d_busy [NI];
  logic        d_done [NI];
  logic        d_rdy  [NI];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  demux_1x32_ctrl_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].req_valid   = req_valid;
    assign bus[g].req_dest    = req_dest;
    assign bus[g].req_data    = req_data;
    assign bus[g].sweep_start = sweep_start;
    demux_1x32_ctrl #(.HOLD_CYCLES(HV[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    assign d_sel[g]  = bus[g].sel;
    assign d_i[g]    = bus[g].i;
    assign d_y[g]    = bus[g].y;
    assign d_busy[g] = bus[g].busy;
    assign d_done[g] = bus[g].done;
    assign d_rdy[g]  = bus[g].req_ready;
  end

  // Model: an active job is a route or sweep with t cycles elapsed since acceptance.
  logic       m_act   [NI] = '{default: 1'b0};
  logic       m_sweep [NI] = '{default: 1'b0};
  int         m_t     [NI] = '{default: 0};
  logic [4:0] m_dest  [NI] = '{default: '0};
  logic       m_data  [NI] = '{default: 1'b0};
  logic [4:0] m_last  [NI] = '{default: '0};

  function automatic exp_t model_out(int k);
    exp_t e;
    e.sel = m_last[k]; e.i = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    if (m_act[k]) begin
      if (m_sweep[k]) begin
        if (m_t[k] < 32 * HV[k]) begin
          e.sel = 5'(m_t[k] / HV[k]); e.i = 1'b1; e.busy = 1'b1;
        end else begin
          e.sel = 5'd31; e.done = 1'b1;
        end
      end else begin
        e.sel = m_dest[k];
        if (m_t[k] < HV[k]) begin
          e.i = m_data[k]; e.busy = 1'b1;
        end else begin
          e.done = 1'b1;
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    if (rst) started <= 1'b1;
    for (int k = 0; k < NI; k++) begin
      e = model_out(k);
      if (rst) begin
        m_act[k] <= 1'b0; m_last[k] <= '0; m_t[k] <= 0;
      end else if (e.busy) begin
        m_t[k] <= m_t[k] + 1;
      end else begin
        m_last[k] <= e.sel;
        m_t[k]    <= 0;
        if (sweep_start) begin
          m_act[k] <= 1'b1; m_sweep[k] <= 1'b1;
        end else if (req_valid) begin
          m_act[k] <= 1'b1; m_sweep[k] <= 1'b0;
          m_dest[k] <= req_dest; m_data[k] <= req_data;
        end else begin
          m_act[k] <= 1'b0;
        end
      end
    end
  end

  task automatic compare_loop();
    exp_t e;
    logic [31:0] ey;
    logic er;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < NI; k++) begin
          e  = model_out(k);
          ey = e.i ? (32'h1 << e.sel) : 32'h0;
          er = !e.busy && !sweep_start && !rst;
          tests++;
          if (d_sel[k] !== e.sel || d_i[k] !== e.i || d_y[k] !== ey ||
              d_busy[k] !== e.busy || d_done[k] !== e.done || d_rdy[k] !== er) begin
            fails++;
            $display("FAIL model H=%0d cyc %0d sel/i/y/busy/done/ready got %0d/%b/%h/%b/%b/%b exp %0d/%b/%h/%b/%b/%b",
                     HV[k], cyc, d_sel[k], d_i[k], d_y[k], d_busy[k], d_done[k], d_rdy[k],
                     e.sel, e.i, ey, e.busy, e.done, er);
          end
        end
      end
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!d_busy[0] && !d_busy[1] && !d_busy[2]) return;
    end
    pin("idle timeout", 32'd1, 32'd0);
  endtask

  logic [31:0] s2y [9] = '{32'h1, 32'h1, 32'h0, 32'h8000_0000, 32'h8000_0000,
                           32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] ytr [0:499];
  logic [4:0]  seltr [0:15];
  logic        dtr [0:499];
  logic        rdy;
  int          accepted, dn, d0, d1, d2;

  initial begin
    fork
      compare_loop();
    join_none

    // Reset
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    pin("reset sel", 32'(d_sel[0]), 32'd0);
    pin("reset y", d_y[0], 32'd0);
    pin("reset busy", 32'(d_busy[0]), 32'd0);
    pin("reset ready", 32'(d_rdy[0]), 32'd0);
    tick();

    // Single route dest 5, data 1
    rst = 1'b0; req_dest = 5'd5; req_data = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    pin("route c1 y", d_y[0], 32'h0000_0020);
    pin("route c1 ready", 32'(d_rdy[0]), 32'd0);
    pin("route h1 c1 y", d_y[1], 32'h0000_0020);
    @(negedge clk);
    pin("route c2 y", d_y[0], 32'h0000_0020);
    pin("route h1 c2 done", 32'(d_done[1]), 32'd1);
    @(negedge clk);
    pin("route c3 y", d_y[0], 32'd0);
    pin("route c3 done", 32'(d_done[0]), 32'd1);
    pin("route c3 ready", 32'(d_rdy[0]), 32'd1);
    wait_idle();
    tick();

    // Back-to-back with valid held
    req_dest = 5'd0; req_data = 1'b1; req_valid = 1'b1;
    accepted = 0; dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (accepted > 0) begin
        ytr[c-1] = d_y[0]; seltr[c-1] = d_sel[0];
        if (d_done[0]) dn++;
      end
      rdy = d_rdy[0];
      tick();
      if (rdy && req_valid) begin
        accepted++;
        case (accepted)
          1: begin req_dest = 5'd31; req_data = 1'b1; end
          2: begin req_dest = 5'd7;  req_data = 1'b0; end
          default: req_valid = 1'b0;
        endcase
      end
    end
    for (int j = 0; j < 9; j++) pin("b2b y", ytr[j], s2y[j]);
    for (int j = 6; j < 9; j++) pin("b2b sel", 32'(seltr[j]), 32'd7);
    pin("b2b done count", 32'(dn), 32'd3);
    wait_idle();
    tick();

    // Sweep with simultaneous held request; re-pulses mid-sweep and mid-route
    sweep_start = 1'b1; req_valid = 1'b1; req_dest = 5'd3; req_data = 1'b1;
    tick();
    sweep_start = 1'b0;
    d0 = 0; d1 = 0; d2 = 0;
    for (int n = 1; n < 490; n++) begin
      @(negedge clk);
      ytr[n] = d_y[0]; dtr[n] = d_done[0];
      if (n == 1) pin("sweep c1 ready", 32'(d_rdy[0]), 32'd0);
      if (d_done[0] && d0 == 0) d0 = n;
      if (d_done[1] && d1 == 0) d1 = n;
      if (d_done[2] && d2 == 0) d2 = n;
      tick();
      if (n == 20 || n == 65) sweep_start = 1'b1;
      if (n == 21 || n == 66) sweep_start = 1'b0;
      if (n == 65) req_valid = 1'b0;
    end
    for (int n = 1; n <= 64; n++) pin("sweep walk y", ytr[n], 32'h1 << ((n - 1) / 2));
    pin("sweep c65 y", ytr[65], 32'd0);
    pin("sweep done h2", 32'(d0), 32'd65);
    pin("sweep done h1", 32'(d1), 32'd33);
    pin("sweep done h15", 32'(d2), 32'd481);
    pin("held req c66 y", ytr[66], 32'h8);
    pin("held req c67 y", ytr[67], 32'h8);
    pin("held req c68 done", 32'(dtr[68]), 32'd1);
    wait_idle();
    tick();

    // Reset during sweep channel 10
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    rst = 1'b1;
    @(negedge clk);
    pin("abort pre sel", 32'(d_sel[0]), 32'd10);
    tick();
    rst = 1'b0;
    @(negedge clk);
    pin("abort sel", 32'(d_sel[0]), 32'd0);
    pin("abort i", 32'(d_i[0]), 32'd0);
    pin("abort y", d_y[0], 32'd0);
    pin("abort busy", 32'(d_busy[0]), 32'd0);
    dn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (d_done[0]) dn++;
    end
    pin("abort no done", 32'(dn), 32'd0);
    tick();

    // Hold-time corners: dest 12
    req_dest = 5'd12; req_data = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 1) begin
        pin("h1 d12 y", d_y[1], 32'h0000_1000);
        pin("h15 d12 c1 y", d_y[2], 32'h0000_1000);
      end
      if (n == 2) pin("h1 d12 done", 32'(d_done[1]), 32'd1);
      if (n == 15) pin("h15 d12 c15 y", d_y[2], 32'h0000_1000);
      if (n == 16) begin
        pin("h15 d12 c16 y", d_y[2], 32'd0);
        pin("h15 d12 done", 32'(d_done[2]), 32'd1);
      end
    end
    wait_idle();

    // Randomized traffic, including occasional sweeps and resets
    for (int n = 0; n < 4000; n++) begin
      tick();
      req_valid   = ($urandom_range(0, 3) != 0);
      req_dest    = 5'($urandom_range(0, 31));
      req_data    = 1'($urandom_range(0, 1));
      sweep_start = ($urandom_range(0, 150) == 0);
      rst         = ($urandom_range(0, 400) == 0);
    end
    tick();
    req_valid = 1'b0; sweep_start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
